// File: rtl/tis_node_sequencer_pkg.sv
// Shared encodings for the TIS node sequencer: opcodes, operand selectors,
// ALU operation codes, FSM states and next-pc jump kinds.
package tis_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_SWP = 4'd2;
  localparam logic [3:0] OP_SAV = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JEZ = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9;
  localparam logic [3:0] OP_JGZ = 4'd10;
  localparam logic [3:0] OP_JLZ = 4'd11;
  localparam logic [3:0] OP_JRO = 4'd12;

  localparam logic [2:0] SRC_IMM   = 3'd0;
  localparam logic [2:0] SEL_ACC   = 3'd1;
  localparam logic [2:0] SEL_NIL   = 3'd2;
  localparam logic [2:0] SEL_PORT0 = 3'd3;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_WR = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    JK_SEQ = 2'd0,
    JK_ABS = 2'd1,
    JK_REL = 2'd2
  } jump_kind_t;

endpackage

// File: rtl/tis_node_sequencer_if.sv
// Neighbour-port handshake bundle: one read and one write request/ack pair per port.
interface tis_node_sequencer_if #(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0] rd_req_o;
  logic [N_PORTS-1:0] rd_valid_i;
  logic [N_PORTS-1:0] wr_req_o;
  logic [N_PORTS-1:0] wr_ready_i;

  modport master (output rd_req_o, output wr_req_o, input rd_valid_i, input wr_ready_i);
  modport slave  (input rd_req_o, input wr_req_o, output rd_valid_i, output wr_ready_i);
endinterface

// File: rtl/tis_pc_next.sv
// Combinational next-pc: sequential wrap, absolute-target range check and
// saturating signed relative jump (JRO).
module tis_pc_next
  import tis_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W:0]     prog_len,
  input  jump_kind_t        kind,
  input  logic              taken,
  input  logic [PC_W-1:0]   target,
  input  logic [DATA_W-1:0] offset,
  output logic [PC_W-1:0]   next_pc
);
  localparam int W = PC_W + DATA_W + 1;

  logic [PC_W:0]         inc;
  logic [PC_W:0]         len_m1;
  logic signed [W-1:0]   pc_ext;
  logic signed [W-1:0]   off_ext;
  logic signed [W-1:0]   len_ext;
  logic signed [W-1:0]   sum;

  always_comb begin
    inc     = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
    len_m1  = prog_len - {{PC_W{1'b0}}, 1'b1};
    pc_ext  = signed'({{(W-PC_W){1'b0}}, pc});
    off_ext = signed'({{(W-DATA_W){offset[DATA_W-1]}}, offset});
    len_ext = signed'({{(W-PC_W-1){1'b0}}, prog_len});
    // Wide enough that pc + offset can never overflow before saturation.
    sum     = pc_ext + off_ext;
    next_pc = '0;
    if (prog_len == '0) begin
      next_pc = '0;
    end else if (kind == JK_REL) begin
      if (sum[W-1])            next_pc = '0;
      else if (sum >= len_ext) next_pc = len_m1[PC_W-1:0];
      else                     next_pc = sum[PC_W-1:0];
    end else if (kind == JK_ABS && taken) begin
      next_pc = ({1'b0, target} >= prog_len) ? '0 : target;
    end else begin
      next_pc = (inc >= prog_len) ? '0 : inc[PC_W-1:0];
    end
  end
endmodule

// File: rtl/tis_node_sequencer.sv
// TIS node sequencer: pc ownership, instruction decode and neighbour-port stalls.
// Optional build macro TIS_SEQ_ILLEGAL_TRAP_EN traps illegal opcodes into HALT.
module tis_node_sequencer
  import tis_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PROG_DEPTH = 16,
  parameter int N_PORTS    = 4,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           instr_op,
  input  logic [2:0]           instr_src,
  input  logic [2:0]           instr_dst,
  input  logic [DATA_W-1:0]    instr_imm,
  input  logic [PC_W:0]        prog_len,
  input  logic [DATA_W-1:0]    acc_i,
  input  logic [DATA_W-1:0]    operand_i,
  tis_node_sequencer_if.master nb,
  output logic [PC_W-1:0]      pc_o,
  output logic [1:0]           alu_op_o,
  output logic                 acc_we_o,
  output logic                 bak_we_o,
  output logic                 swap_o,
  output logic                 commit_o,
  output logic                 illegal_o
);
  localparam logic [2:0] NP = 3'(N_PORTS);

  state_t             state, state_nxt;
  jump_kind_t         kind;
  logic [PC_W-1:0]    pc, pc_nxt, pc_jump;
  logic [2:0]         src_k, dst_k;
  logic [N_PORTS-1:0] rd_sel, wr_sel, rd_req, wr_req;
  logic               uses_src, src_port, dst_port, rd_ok, wr_ok;
  logic               pc_oob, taken, commit;
  logic               acc_we, bak_we, swap;
  logic [1:0]         alu_op;
  logic               unused_imm;

  assign unused_imm = ^instr_imm[DATA_W-1:PC_W];

  always_comb begin
    src_k    = instr_src - SEL_PORT0;
    dst_k    = instr_dst - SEL_PORT0;
    uses_src = (instr_op == OP_MOV) || (instr_op == OP_ADD) ||
               (instr_op == OP_SUB) || (instr_op == OP_JRO);
    src_port = uses_src && (instr_src >= SEL_PORT0) && (src_k < NP);
    dst_port = (instr_op == OP_MOV) && (instr_dst >= SEL_PORT0) && (dst_k < NP);
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      rd_sel[k] = src_port && (src_k == 3'(k));
      wr_sel[k] = dst_port && (dst_k == 3'(k));
    end
    rd_ok  = |(rd_sel & nb.rd_valid_i);
    wr_ok  = |(wr_sel & nb.wr_ready_i);
    pc_oob = ({1'b0, pc} >= prog_len);
  end

  always_comb begin
    kind  = JK_SEQ;
    taken = 1'b0;
    case (instr_op)
      OP_JMP: begin kind = JK_ABS; taken = 1'b1; end
      OP_JEZ: begin kind = JK_ABS; taken = (acc_i == '0); end
      OP_JNZ: begin kind = JK_ABS; taken = (acc_i != '0); end
      OP_JGZ: begin kind = JK_ABS; taken = !acc_i[DATA_W-1] && (acc_i != '0); end
      OP_JLZ: begin kind = JK_ABS; taken = acc_i[DATA_W-1]; end
      OP_JRO: kind = JK_REL;
      default: ;
    endcase
  end

  tis_pc_next #(.DATA_W(DATA_W), .PC_W(PC_W)) u_pc_next (
    .pc       (pc),
    .prog_len (prog_len),
    .kind     (kind),
    .taken    (taken),
    .target   (instr_imm[PC_W-1:0]),
    .offset   (operand_i),
    .next_pc  (pc_jump)
  );

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    rd_req    = '0;
    wr_req    = '0;
    case (state)
      ST_RUN: begin
        if (!pc_oob) begin
`ifdef TIS_SEQ_ILLEGAL_TRAP_EN
          if (instr_op > OP_JRO) begin
            state_nxt = ST_HALT;
          end else
`endif
          if (src_port) begin
            rd_req = rd_sel;
            // A read feeding a port write retires only once the write is accepted.
            if (rd_ok) begin
              if (dst_port) state_nxt = ST_WAIT_WR;
              else          commit    = 1'b1;
            end
          end else if (dst_port) begin
            wr_req = wr_sel;
            commit = wr_ok;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_WAIT_WR: begin
        if (pc_oob) begin
          state_nxt = ST_RUN;
        end else begin
          wr_req = wr_sel;
          if (wr_ok) begin
            commit    = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_we = 1'b0;
    bak_we = 1'b0;
    swap   = 1'b0;
    alu_op = ALU_PASS;
    if (commit) begin
      case (instr_op)
        OP_MOV: acc_we = (instr_dst == SEL_ACC);
        OP_ADD: begin acc_we = 1'b1; alu_op = ALU_ADD; end
        OP_SUB: begin acc_we = 1'b1; alu_op = ALU_SUB; end
        OP_NEG: begin acc_we = 1'b1; alu_op = ALU_NEG; end
        OP_SAV: bak_we = 1'b1;
        OP_SWP: swap   = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (state == ST_HALT) pc_nxt = pc;
    else if (pc_oob)      pc_nxt = '0;
    else if (commit)      pc_nxt = pc_jump;
    else                  pc_nxt = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      state <= ST_RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

`ifdef TIS_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              illegal_q <= 1'b0;
    else if (state == ST_RUN && !pc_oob && instr_op > OP_JRO) illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  // Requests and strobes fall combinationally with rst, even mid-handshake.
  assign pc_o        = pc;
  assign nb.rd_req_o = rst ? '0 : rd_req;
  assign nb.wr_req_o = rst ? '0 : wr_req;
  assign commit_o    = commit & ~rst;
  assign acc_we_o    = acc_we & ~rst;
  assign bak_we_o    = bak_we & ~rst;
  assign swap_o      = swap & ~rst;
  assign alu_op_o    = rst ? ALU_PASS : alu_op;
endmodule

// File: tb/tb_tis_node_sequencer.sv
// Table-driven bench for tis_node_sequencer with an expected-result queue.
module tb_tis_node_sequencer;
  import tis_seq_pkg::*;

  localparam int DATA_W     = 8;
  localparam int PROG_DEPTH = 16;
  localparam int N_PORTS    = 4;
`ifdef TIS_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] instr_op  = 4'd0;
  logic [2:0] instr_src = 3'd0;
  logic [2:0] instr_dst = 3'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [4:0] prog_len  = 5'd0;
  logic [7:0] acc_i     = 8'd0;
  logic [7:0] operand_i = 8'd0;
  logic [3:0] pc_o;
  logic [1:0] alu_op_o;
  logic       acc_we_o, bak_we_o, swap_o, commit_o, illegal_o;

  tis_node_sequencer_if #(.N_PORTS(N_PORTS)) nb ();

  tis_node_sequencer #(.DATA_W(DATA_W), .PROG_DEPTH(PROG_DEPTH), .N_PORTS(N_PORTS)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .instr_src(instr_src), .instr_dst(instr_dst),
    .instr_imm(instr_imm), .prog_len(prog_len), .acc_i(acc_i), .operand_i(operand_i),
    .nb(nb), .pc_o(pc_o), .alu_op_o(alu_op_o), .acc_we_o(acc_we_o), .bak_we_o(bak_we_o),
    .swap_o(swap_o), .commit_o(commit_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;  logic [2:0] src; logic [2:0] dst; logic [7:0] imm; logic [4:0] len;
    logic [7:0] acc; logic [7:0] opd; logic [3:0] rv;  logic [3:0] wr;
    logic [3:0] pc;  logic c; logic aw; logic bw; logic sw; logic [1:0] alu;
    logic [3:0] rdq; logic [3:0] wrq; logic ill;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic [3:0] op, input logic [2:0] src, input logic [2:0] dst, input logic [7:0] imm,
    input logic [4:0] len, input logic [7:0] acc, input logic [7:0] opd, input logic [3:0] rv,
    input logic [3:0] wr, input logic [3:0] pc, input logic c, input logic aw, input logic bw,
    input logic sw, input logic [1:0] alu, input logic [3:0] rdq, input logic [3:0] wrq,
    input logic ill);
    vec_t v;
    v.op = op; v.src = src; v.dst = dst; v.imm = imm; v.len = len; v.acc = acc; v.opd = opd;
    v.rv = rv; v.wr = wr; v.pc = pc; v.c = c; v.aw = aw; v.bw = bw; v.sw = sw; v.alu = alu;
    v.rdq = rdq; v.wrq = wrq; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    instr_op = v.op; instr_src = v.src; instr_dst = v.dst; instr_imm = v.imm;
    prog_len = v.len; acc_i = v.acc; operand_i = v.opd;
    nb.rd_valid_i = v.rv; nb.wr_ready_i = v.wr;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " pc"},      {4'd0, pc_o},        {4'd0, e.pc});
      chk({tag, " commit"},  {7'd0, commit_o},    {7'd0, e.c});
      chk({tag, " acc_we"},  {7'd0, acc_we_o},    {7'd0, e.aw});
      chk({tag, " bak_we"},  {7'd0, bak_we_o},    {7'd0, e.bw});
      chk({tag, " swap"},    {7'd0, swap_o},      {7'd0, e.sw});
      chk({tag, " alu_op"},  {6'd0, alu_op_o},    {6'd0, e.alu});
      chk({tag, " rd_req"},  {4'd0, nb.rd_req_o}, {4'd0, e.rdq});
      chk({tag, " wr_req"},  {4'd0, nb.wr_req_o}, {4'd0, e.wrq});
      chk({tag, " illegal"}, {7'd0, illegal_o},   {7'd0, e.ill});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nb.rd_valid_i = 4'd0;
    nb.wr_ready_i = 4'd0;

    // Reset with a port-read instruction present: nothing may be requested.
    instr_op = OP_MOV; instr_src = 3'd3; instr_dst = SEL_ACC; prog_len = 5'd16;
    @(negedge clk);
    chk("reset pc",      {4'd0, pc_o},        8'd0);
    chk("reset rd_req",  {4'd0, nb.rd_req_o}, 8'd0);
    chk("reset commit",  {7'd0, commit_o},    8'd0);
    chk("reset acc_we",  {7'd0, acc_we_o},    8'd0);
    chk("reset illegal", {7'd0, illegal_o},   8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //          op     src   dst   imm    len    acc    opd    rv     wr     pc     c     aw    bw    sw    alu    rdq    wrq    ill
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd3, 8'h00,8'h00,4'd0,4'd0, 4'd0, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd3, 8'h00,8'h00,4'd0,4'd0, 4'd1, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd3, 8'h00,8'h00,4'd0,4'd0, 4'd2, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd3, 8'h00,8'h00,4'd0,4'd0, 4'd0, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd3, 8'h00,8'h00,4'd0,4'd0, 4'd1, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_ADD,3'd0,3'd0,8'd5, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd2, 1'b1,1'b1,1'b0,1'b0,2'b01,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JLZ,3'd0,3'd0,8'd2, 5'd16,8'hFB,8'h00,4'd0,4'd0, 4'd3, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JGZ,3'd0,3'd0,8'd9, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd2, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JEZ,3'd0,3'd0,8'd7, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd3, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_SAV,3'd0,3'd0,8'd0, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd7, 1'b1,1'b0,1'b1,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_SWP,3'd0,3'd0,8'd0, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd8, 1'b1,1'b0,1'b0,1'b1,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_SUB,3'd1,3'd0,8'd0, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd9, 1'b1,1'b1,1'b0,1'b0,2'b10,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NEG,3'd0,3'd0,8'd0, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd10,1'b1,1'b1,1'b0,1'b0,2'b11,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JMP,3'd0,3'd0,8'd13,5'd12,8'h00,8'h00,4'd0,4'd0, 4'd11,1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JNZ,3'd0,3'd0,8'd5, 5'd16,8'h80,8'h00,4'd0,4'd0, 4'd0, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JGZ,3'd0,3'd0,8'd1, 5'd16,8'h7F,8'h00,4'd0,4'd0, 4'd5, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JLZ,3'd0,3'd0,8'd9, 5'd16,8'h01,8'h00,4'd0,4'd0, 4'd1, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_MOV,3'd0,3'd1,8'd3, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd2, 1'b1,1'b1,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JRO,3'd0,3'd0,8'd0, 5'd16,8'h00,8'hEC,4'd0,4'd0, 4'd3, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JRO,3'd0,3'd0,8'd0, 5'd10,8'h00,8'd100,4'd0,4'd0,4'd0, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_JRO,3'd0,3'd0,8'd0, 5'd10,8'h00,8'hFE,4'd0,4'd0, 4'd9, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_MOV,3'd0,3'd2,8'd0, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd7, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd5, 8'h00,8'h00,4'd0,4'd0, 4'd8, 1'b0,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd0, 8'h00,8'h00,4'd0,4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_MOV,3'd3,3'd1,8'd0, 5'd0, 8'h00,8'h00,4'd0,4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    tbl.push_back(mk(OP_MOV,3'd0,3'd6,8'd0, 5'd16,8'h00,8'h00,4'd0,4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,2'b00,4'd0,4'b1000,1'b0));
    tbl.push_back(mk(OP_MOV,3'd0,3'd6,8'd0, 5'd16,8'h00,8'h00,4'd0,4'b1000,4'd0,1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'b1000,1'b0));
    tbl.push_back(mk(OP_NOP,3'd0,3'd0,8'd0, 5'd2, 8'h00,8'h00,4'd0,4'd0, 4'd1, 1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("t%0d", i));

    // Read stall on port 0: three cycles without valid (other ports valid once), then valid.
    apply(mk(OP_MOV,3'd3,3'd1,8'd0,5'd16,8'h00,8'h00,4'b0000,4'd0, 4'd0,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0001,4'd0,1'b0), "rd0");
    apply(mk(OP_MOV,3'd3,3'd1,8'd0,5'd16,8'h00,8'h00,4'b1110,4'd0, 4'd0,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0001,4'd0,1'b0), "rd1");
    apply(mk(OP_MOV,3'd3,3'd1,8'd0,5'd16,8'h00,8'h00,4'b0000,4'd0, 4'd0,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0001,4'd0,1'b0), "rd2");
    apply(mk(OP_MOV,3'd3,3'd1,8'd0,5'd16,8'h00,8'h00,4'b0001,4'd0, 4'd0,1'b1,1'b1,1'b0,1'b0,2'b00,4'b0001,4'd0,1'b0), "rd3");

    // Port 1 -> port 2: immediate read, WAIT_WR for two cycles, then accepted.
    apply(mk(OP_MOV,3'd4,3'd5,8'd0,5'd16,8'h00,8'h00,4'b0010,4'b0000,4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0010,4'd0,1'b0), "pp0");
    apply(mk(OP_MOV,3'd4,3'd5,8'd0,5'd16,8'h00,8'h00,4'b0010,4'b0000,4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,4'd0,4'b0100,1'b0), "pp1");
    apply(mk(OP_MOV,3'd4,3'd5,8'd0,5'd16,8'h00,8'h00,4'b0000,4'b1011,4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,4'd0,4'b0100,1'b0), "pp2");
    apply(mk(OP_MOV,3'd4,3'd5,8'd0,5'd16,8'h00,8'h00,4'b0000,4'b0100,4'd1,1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'b0100,1'b0), "pp3");

    // JRO sourced from port 2 waits for the read, then jumps by +2.
    apply(mk(OP_JRO,3'd5,3'd0,8'd0,5'd16,8'h00,8'h09,4'b0000,4'd0, 4'd2,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0100,4'd0,1'b0), "jr0");
    apply(mk(OP_JRO,3'd5,3'd0,8'd0,5'd16,8'h00,8'h02,4'b0100,4'd0, 4'd2,1'b1,1'b0,1'b0,1'b0,2'b00,4'b0100,4'd0,1'b0), "jr1");

    // Illegal opcode: trap build halts with pc frozen, default build treats it as NOP.
    apply(mk(4'd14,3'd0,3'd0,8'd0,5'd16,8'h00,8'h00,4'd0,4'd0, 4'd4,!TRAP,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0), "il0");
    apply(mk(OP_NOP,3'd0,3'd0,8'd0,5'd16,8'h00,8'h00,4'd0,4'd0, TRAP ? 4'd4 : 4'd5,!TRAP,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,TRAP), "il1");
    apply(mk(OP_MOV,3'd3,3'd1,8'd0,5'd16,8'h00,8'h00,4'd0,4'd0, TRAP ? 4'd4 : 4'd6,1'b0,1'b0,1'b0,1'b0,2'b00,
             TRAP ? 4'd0 : 4'b0001,4'd0,TRAP), "il2");

    // Asynchronous reset during the stall: everything drops before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst rd_req",  {4'd0, nb.rd_req_o}, 8'd0);
    chk("mid rst wr_req",  {4'd0, nb.wr_req_o}, 8'd0);
    chk("mid rst pc",      {4'd0, pc_o},        8'd0);
    chk("mid rst commit",  {7'd0, commit_o},    8'd0);
    chk("mid rst illegal", {7'd0, illegal_o},   8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply(mk(OP_NOP,3'd0,3'd0,8'd0,5'd16,8'h00,8'h00,4'd0,4'd0, 4'd0,1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0), "post0");
    apply(mk(OP_NOP,3'd0,3'd0,8'd0,5'd16,8'h00,8'h00,4'd0,4'd0, 4'd1,1'b1,1'b0,1'b0,1'b0,2'b00,4'd0,4'd0,1'b0), "post1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tis_node_sequencer.md
Name: tis_node_sequencer

Overview:
- Sequential control unit for one TIS execution node: owns the program counter and decodes the current instruction into datapath strobes.
- Performs port read/write handshakes with neighbour nodes, stalling until they complete.
- Successor to the combinational decoder, generalised in the following ways:
  - parametrised data width, program depth and port count;
  - correct signed jump conditions;
  - JRO with saturation;
  - multi-cycle port stalls.
- Sits between program memory (combinational read at pc_o) and the node datapath (ACC/BAK/ALU).

Parameters:
DATA_W, 8, width of ACC, immediate and operand
PROG_DEPTH, 16, program memory depth in instructions
PC_W, $clog2(PROG_DEPTH), program counter width (derived; do not override)
N_PORTS, 4, neighbour ports, legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_op  in  4  opcode: 0 NOP, 1 MOV, 2 SWP, 3 SAV, 4 ADD, 5 SUB, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ, 12 JRO, 13-15 illegal
instr_src  in  3  source: 0 IMM, 1 ACC, 2 NIL, 3+k port k
instr_dst  in  3  MOV destination: 1 ACC, 2 NIL, 3+k port k
instr_imm  in  DATA_W  immediate / absolute jump target (low PC_W bits)
prog_len  in  PC_W+1  number of valid instructions, 0..PROG_DEPTH
acc_i  in  DATA_W  current ACC, two's complement
operand_i  in  DATA_W  resolved source value from datapath (used by JRO)
pc_o  out  PC_W  program counter
rd_req_o  out  N_PORTS  one-hot read request
rd_valid_i  in  N_PORTS  per-port read data valid
wr_req_o  out  N_PORTS  one-hot write request
wr_ready_i  in  N_PORTS  per-port write accepted
alu_op_o  out  2  00 pass, 01 add, 10 sub, 11 neg
acc_we_o  out  1  ACC write strobe
bak_we_o  out  1  BAK write strobe
swap_o  out  1  ACC<->BAK exchange
commit_o  out  1  instruction retires this cycle
illegal_o  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: asynchronous, active-high, one clock domain.
  - pc_o=0; state RUN; illegal_o=0.
  - All request and strobe outputs are 0 while rst is high, including mid-handshake: requests drop immediately.
- FSM states: RUN, WAIT_WR, HALT.
- RUN, no port involved: instruction commits in 1 cycle. commit_o=1 and the strobes are combinational in that cycle; pc updates at the edge.
- RUN, source is port k:
  - rd_req_o[k]=1.
  - If rd_valid_i[k]=0: stall, pc held, no strobes.
  - On valid with non-port dst: commit.
  - On valid with dst port j: go to WAIT_WR. The datapath latches the read data.
- RUN, non-port source, dst port j: wr_req_o[j]=1; stall until wr_ready_i[j]; commit that cycle.
- WAIT_WR: wr_req_o[j]=1, rd_req_o=0; commit on wr_ready_i[j] and return to RUN.
- Requests stay asserted, with instr_* required stable, until handshake completion.
- Strobes at commit only:
  - MOV dst ACC: acc_we_o.
  - ADD/SUB/NEG: acc_we_o with alu_op 01/10/11.
  - SAV: bak_we_o.
  - SWP: swap_o.
  - NOP, MOV to NIL and jumps: commit_o only.
- Next pc:
  - Default pc+1, wrapping to 0 when pc+1 >= prog_len.
  - JMP: target = instr_imm[PC_W-1:0]; if target >= prog_len, next pc = 0.
  - Conditional jumps (taken → JMP target, else default): JEZ if acc_i==0; JNZ if !=0; JGZ if signed >0; JLZ if signed <0.
  - JRO: pc + signed operand_i, computed at PC_W+DATA_W+1 bits, saturated to [0, prog_len-1]. JRO with a port source waits for the read like any read.
- prog_len==0: pc stays 0, nothing decoded, no requests, commit_o=0.
- If pc_o >= prog_len (prog_len lowered at run time): next pc = 0, no commit.
- Illegal opcode: behaves as NOP (commit, pc+1).

Optional Feature:
TIS_SEQ_ILLEGAL_TRAP_EN
- Defined: an illegal opcode sets illegal_o at the edge and enters HALT.
  - HALT: pc frozen, all requests and strobes 0, commit_o=0, exit only by rst.
- Undefined: illegal opcodes are NOPs, HALT is unreachable, illegal_o is tied 0.

Decomposition:
- Package tis_seq_pkg holds:
  - opcode localparams;
  - src/dst encodings (SRC_IMM, SEL_ACC, SEL_NIL, SEL_PORT0);
  - alu_op encodings;
  - FSM state enum.
- One sub-module, tis_pc_next: pure combinational next-pc. Inputs are pc, prog_len, jump kind, condition result, target and JRO offset; it performs wrap, range check and saturation.

Test Plan:
- prog_len=3, NOPs → pc 0,1,2,0,1; commit_o every cycle.
- ADD IMM 5 → commit, acc_we_o=1, alu_op=01. Then JLZ with acc_i=8'hFB → taken to imm 2. JGZ with acc_i=0 → not taken. JEZ with acc_i=0 → taken.
- MOV port0→ACC, rd_valid_i[0] low 3 cycles → rd_req_o=0001 for 4 cycles, pc held; on valid: acc_we_o, commit, pc+1.
- MOV port1→port2, read immediate, wr_ready_i[2] after 2 cycles → RUN then WAIT_WR with wr_req_o=0100; commit on ready; rd_req_o=0 during WAIT_WR.
- JRO operand=-20 at pc=3 → pc 0; operand=+100 with prog_len=10 → pc 9.
- Opcode 14 with macro defined → illegal_o=1, pc frozen, no commits; rst asserted mid-stall → pc 0, requests drop the same cycle, illegal_o clears.
